// File: rtl/arc4_stream_core.sv
// ARC4 (RC4-drop[n]) decrypt engine: reads a length-prefixed ciphertext from CT RAM,
// writes the length-prefixed plaintext to PT RAM. Key length and discard count are parameters.
module arc4_stream_core #(
  parameter int unsigned KEY_BYTES = 3,
  parameter int unsigned DROP_N    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [KEY_BYTES*8-1:0] key,
  output logic [7:0]             ct_addr,
  input  logic [7:0]             ct_rddata,
  output logic [7:0]             pt_addr,
  output logic [7:0]             pt_wrdata,
  output logic                   pt_wren
);

  localparam int unsigned KEY_W  = KEY_BYTES * 8;
  localparam int unsigned KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int unsigned CNT_W  = 11;
  localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);
  localparam logic [CNT_W-1:0]  DROP_LAST = CNT_W'(DROP_N - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_KSA,
    ST_DROP,
    ST_LEN0,
    ST_LEN1,
    ST_LEN2,
    ST_PRGA_A,
    ST_PRGA_B,
    ST_FLUSH,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         i_q, i_d;
  logic [7:0]         j_q, j_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [KIDX_W-1:0]  kidx_q, kidx_d;
  logic [7:0]         len_q, len_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic               rdy_q, rdy_d;
  logic [7:0]         ct_addr_q, ct_addr_d;
  logic [7:0]         pt_addr_q, pt_addr_d;
  logic [7:0]         pt_wrdata_q, pt_wrdata_d;
  logic               pt_wren_q, pt_wren_d;

  logic [7:0]         s_mem [256];
  logic               s_we_a, s_we_b;
  logic [7:0]         s_wa_a, s_wa_b;
  logic [7:0]         s_wd_a, s_wd_b;

  logic [7:0]         key_byte [KEY_BYTES];
  logic [7:0]         s_i_cur, s_j_cur;
  logic [7:0]         j_ksa, s_j_ksa;
  logic [7:0]         i_step, s_i_step, j_step, s_j_step;
  logic [7:0]         pad;

  // Key byte 0 sits in the most significant byte of the key bus.
  for (genvar g = 0; g < KEY_BYTES; g++) begin : g_key
    assign key_byte[g] = key_q[8*(KEY_BYTES-1-g) +: 8];
  end

  // KSA step reads S[i]; DROP/PRGA step reads S[i+1]; pad uses the already-swapped S.
  assign s_i_cur  = s_mem[i_q];
  assign s_j_cur  = s_mem[j_q];
  assign j_ksa    = j_q + s_i_cur + key_byte[kidx_q];
  assign s_j_ksa  = s_mem[j_ksa];
  assign i_step   = i_q + 8'd1;
  assign s_i_step = s_mem[i_step];
  assign j_step   = j_q + s_i_step;
  assign s_j_step = s_mem[j_step];
  assign pad      = s_mem[8'(s_i_cur + s_j_cur)];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      cnt_q       <= '0;
      kidx_q      <= '0;
      len_q       <= '0;
      key_q       <= '0;
      rdy_q       <= 1'b1;
      ct_addr_q   <= '0;
      pt_addr_q   <= '0;
      pt_wrdata_q <= '0;
      pt_wren_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      cnt_q       <= cnt_d;
      kidx_q      <= kidx_d;
      len_q       <= len_d;
      key_q       <= key_d;
      rdy_q       <= rdy_d;
      ct_addr_q   <= ct_addr_d;
      pt_addr_q   <= pt_addr_d;
      pt_wrdata_q <= pt_wrdata_d;
      pt_wren_q   <= pt_wren_d;
    end
  end

  // S register file: two write ports so a swap completes in one cycle.
  always_ff @(posedge clk) begin
    if (s_we_a) s_mem[s_wa_a] <= s_wd_a;
    if (s_we_b) s_mem[s_wa_b] <= s_wd_b;
  end

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    cnt_d       = cnt_q;
    kidx_d      = kidx_q;
    len_d       = len_q;
    key_d       = key_q;
    rdy_d       = rdy_q;
    ct_addr_d   = ct_addr_q;
    pt_addr_d   = pt_addr_q;
    pt_wrdata_d = pt_wrdata_q;
    pt_wren_d   = 1'b0;
    s_we_a      = 1'b0;
    s_wa_a      = '0;
    s_wd_a      = '0;
    s_we_b      = 1'b0;
    s_wa_b      = '0;
    s_wd_b      = '0;

    unique case (state_q)
      ST_IDLE: begin
        rdy_d = 1'b1;
        if (en) begin
          key_d   = key;
          rdy_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_INIT;
        end
      end

      ST_INIT: begin
        s_we_a = 1'b1;
        s_wa_a = cnt_q[7:0];
        s_wd_a = cnt_q[7:0];
        cnt_d  = cnt_q + 11'd1;
        if (cnt_q == 11'd255) begin
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          cnt_d   = '0;
          state_d = ST_KSA;
        end
      end

      ST_KSA: begin
        s_we_a = 1'b1;
        s_wa_a = i_q;
        s_wd_a = s_j_ksa;
        s_we_b = 1'b1;
        s_wa_b = j_ksa;
        s_wd_b = s_i_cur;
        i_d    = i_step;
        j_d    = j_ksa;
        kidx_d = (kidx_q == KIDX_LAST) ? '0 : kidx_q + KIDX_W'(1);
        if (i_q == 8'hFF) begin
          i_d   = '0;
          j_d   = '0;
          cnt_d = '0;
          if (DROP_N == 0) begin
            ct_addr_d = '0;
            state_d   = ST_LEN0;
          end else begin
            state_d = ST_DROP;
          end
        end
      end

      ST_DROP: begin
        s_we_a = 1'b1;
        s_wa_a = i_step;
        s_wd_a = s_j_step;
        s_we_b = 1'b1;
        s_wa_b = j_step;
        s_wd_b = s_i_step;
        i_d    = i_step;
        j_d    = j_step;
        cnt_d  = cnt_q + 11'd1;
        if (cnt_q == DROP_LAST) begin
          ct_addr_d = '0;
          state_d   = ST_LEN0;
        end
      end

      ST_LEN0: state_d = ST_LEN1;

      ST_LEN1: begin
        len_d       = ct_rddata;
        pt_addr_d   = '0;
        pt_wrdata_d = ct_rddata;
        pt_wren_d   = 1'b1;
        state_d     = ST_LEN2;
      end

      ST_LEN2: begin
        if (len_q == 8'd0) begin
          state_d = ST_FLUSH;
        end else begin
          cnt_d     = 11'd1;
          ct_addr_d = 8'd1;
          state_d   = ST_PRGA_A;
        end
      end

      ST_PRGA_A: begin
        s_we_a  = 1'b1;
        s_wa_a  = i_step;
        s_wd_a  = s_j_step;
        s_we_b  = 1'b1;
        s_wa_b  = j_step;
        s_wd_b  = s_i_step;
        i_d     = i_step;
        j_d     = j_step;
        state_d = ST_PRGA_B;
      end

      // CT byte for this k arrives now; the write appears on the bus next cycle.
      ST_PRGA_B: begin
        pt_addr_d   = cnt_q[7:0];
        pt_wrdata_d = ct_rddata ^ pad;
        pt_wren_d   = 1'b1;
        if (cnt_q[7:0] == len_q) begin
          state_d = ST_FLUSH;
        end else begin
          cnt_d     = cnt_q + 11'd1;
          ct_addr_d = cnt_q[7:0] + 8'd1;
          state_d   = ST_PRGA_A;
        end
      end

      ST_FLUSH: state_d = ST_DONE;

      ST_DONE: begin
        rdy_d   = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign rdy       = rdy_q;
  assign ct_addr   = ct_addr_q;
  assign pt_addr   = pt_addr_q;
  assign pt_wrdata = pt_wrdata_q;
  assign pt_wren   = pt_wren_q;

endmodule

// File: tb/tb_arc4_stream_core.sv
// Bench for arc4_stream_core: four instances (3-byte key, 3-byte key with drop 768,
// 1-byte key, 16-byte key) checked against a plain RC4-drop reference model.
module tb_arc4_stream_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [3:0]           en, rdy, pt_wren, wr_clr;
  logic [3:0][127:0]    key_v;
  logic [3:0][7:0]      ct_addr, ct_rd, pt_addr, pt_wrdata;
  logic [7:0]           ct_mem [4][256];
  logic [7:0]           pt_mem [4][256];
  int                   wr_cnt [4];
  logic [7:0]           ref_pad [256];
  logic [7:0]           ct_fix [10];
  logic [7:0]           txt [9];
  int                   n_cmp = 0;
  int                   n_bad = 0;

  typedef struct {
    int           unit;
    logic [127:0] key;
    int           len;
    int           mode;     // 0 random CT, 1 "Key"/"Plaintext" vector, 2 zero CT, 3 fixed pattern
    int           exp_lat;
  } vec_t;
  vec_t vecs [8];

  arc4_stream_core #(.KEY_BYTES(3), .DROP_N(0)) u_k3 (
    .clk(clk), .rst(rst), .en(en[0]), .rdy(rdy[0]), .key(key_v[0][23:0]),
    .ct_addr(ct_addr[0]), .ct_rddata(ct_rd[0]), .pt_addr(pt_addr[0]),
    .pt_wrdata(pt_wrdata[0]), .pt_wren(pt_wren[0]));
  arc4_stream_core #(.KEY_BYTES(3), .DROP_N(768)) u_k3_drop (
    .clk(clk), .rst(rst), .en(en[1]), .rdy(rdy[1]), .key(key_v[1][23:0]),
    .ct_addr(ct_addr[1]), .ct_rddata(ct_rd[1]), .pt_addr(pt_addr[1]),
    .pt_wrdata(pt_wrdata[1]), .pt_wren(pt_wren[1]));
  arc4_stream_core #(.KEY_BYTES(1), .DROP_N(0)) u_k1 (
    .clk(clk), .rst(rst), .en(en[2]), .rdy(rdy[2]), .key(key_v[2][7:0]),
    .ct_addr(ct_addr[2]), .ct_rddata(ct_rd[2]), .pt_addr(pt_addr[2]),
    .pt_wrdata(pt_wrdata[2]), .pt_wren(pt_wren[2]));
  arc4_stream_core #(.KEY_BYTES(16), .DROP_N(0)) u_k16 (
    .clk(clk), .rst(rst), .en(en[3]), .rdy(rdy[3]), .key(key_v[3]),
    .ct_addr(ct_addr[3]), .ct_rddata(ct_rd[3]), .pt_addr(pt_addr[3]),
    .pt_wrdata(pt_wrdata[3]), .pt_wren(pt_wren[3]));

  // CT RAM with one-cycle read latency; PT RAM counting every write strobe.
  always @(posedge clk) begin
    for (int u = 0; u < 4; u++) begin
      ct_rd[u] <= ct_mem[u][ct_addr[u]];
      if (wr_clr[u]) begin
        wr_cnt[u] <= 0;
        for (int a = 0; a < 256; a++) pt_mem[u][a] <= 8'hEE;
      end else if (pt_wren[u]) begin
        pt_mem[u][pt_addr[u]] <= pt_wrdata[u];
        wr_cnt[u] <= wr_cnt[u] + 1;
      end
    end
  end

  function automatic int klen_of(input int u);
    if (u <= 1) return 3;
    if (u == 2) return 1;
    return 16;
  endfunction

  function automatic int drop_of(input int u);
    return (u == 1) ? 768 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Textbook RC4 with the first `drop` keystream bytes discarded; pad k lands in ref_pad[k].
  task automatic model(input int klen, input int drop, input int len, input logic [127:0] kv);
    int s [256];
    int i, j, t, kb;
    for (int x = 0; x < 256; x++) s[x] = x;
    j = 0;
    for (int x = 0; x < 256; x++) begin
      kb = int'(kv[8*(klen-1-(x % klen)) +: 8]);
      j = (j + s[x] + kb) % 256;
      t = s[x]; s[x] = s[j]; s[j] = t;
    end
    i = 0;
    j = 0;
    for (int x = 0; x < drop + len; x++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      if (x >= drop) ref_pad[x - drop + 1] = 8'(s[(s[i] + s[j]) % 256]);
    end
  endtask

  task automatic load_ct(input int u, input int len, input int mode);
    ct_mem[u][0] = 8'(len);
    for (int k = 1; k <= len; k++) begin
      case (mode)
        1:       ct_mem[u][k] = ct_fix[k];
        2:       ct_mem[u][k] = 8'h00;
        3:       ct_mem[u][k] = 8'(k * 37 + 5);
        default: ct_mem[u][k] = 8'($urandom);
      endcase
    end
  endtask

  task automatic start(input int u, input logic [127:0] kv);
    @(negedge clk);
    wr_clr[u] = 1'b1;
    @(negedge clk);
    wr_clr[u] = 1'b0;
    key_v[u]  = kv;
    chk($sformatf("u%0d_idle_rdy", u), int'(rdy[u]), 1);
    en[u] = 1'b1;
    @(posedge clk);
    #1;
    chk($sformatf("u%0d_busy_after_accept", u), int'(rdy[u]), 0);
    en[u] = 1'b0;
  endtask

  task automatic wait_done(input int u, output int n);
    n = 0;
    while (rdy[u] !== 1'b1 && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("u%0d_rdy_return", u), int'(rdy[u] === 1'b1), 1);
  endtask

  task automatic check_msg(input int u, input int len, input logic [127:0] kv,
                           input int exp_lat, input int n, input int mode);
    model(klen_of(u), drop_of(u), len, kv);
    chk($sformatf("u%0d_latency", u), n, exp_lat);
    chk($sformatf("u%0d_pt_write_count", u), wr_cnt[u], len + 1);
    chk($sformatf("u%0d_pt_len", u), int'(pt_mem[u][0]), len);
    for (int k = 1; k <= len; k++) begin
      chk($sformatf("u%0d_pt%0d", u, k), int'(pt_mem[u][k]), int'(ct_mem[u][k] ^ ref_pad[k]));
      if (mode == 1) chk($sformatf("u%0d_plaintext%0d", u, k), int'(pt_mem[u][k]), int'(txt[k-1]));
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    load_ct(v.unit, v.len, v.mode);
    start(v.unit, v.key);
    wait_done(v.unit, n);
    check_msg(v.unit, v.len, v.key, v.exp_lat, n, v.mode);
  endtask

  initial begin
    int n, u, len;
    logic [127:0] rk;

    ct_fix[0] = 8'h09; ct_fix[1] = 8'hBB; ct_fix[2] = 8'hF3; ct_fix[3] = 8'h16; ct_fix[4] = 8'hE8;
    ct_fix[5] = 8'hD9; ct_fix[6] = 8'h40; ct_fix[7] = 8'hAF; ct_fix[8] = 8'h0A; ct_fix[9] = 8'hD3;
    txt[0] = 8'h50; txt[1] = 8'h6C; txt[2] = 8'h61; txt[3] = 8'h69; txt[4] = 8'h6E;
    txt[5] = 8'h74; txt[6] = 8'h65; txt[7] = 8'h78; txt[8] = 8'h74;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 256; b++) ct_mem[a][b] = 8'h00;

    // Latency = 256 + 256 + DROP_N + 3 + 2L + 2.
    rk = {$urandom, $urandom, $urandom, $urandom};
    vecs[0] = '{0, 128'h4B6579, 9, 1, 535};
    vecs[1] = '{0, 128'h000018, 16, 3, 549};
    vecs[2] = '{1, 128'h000018, 16, 3, 1317};
    vecs[3] = '{0, rk, 0, 0, 517};
    vecs[4] = '{2, {rk[63:0], rk[127:64]}, 32, 0, 581};
    vecs[5] = '{3, 128'h0102030405060708090a0b0c0d0e0f10, 32, 2, 581};
    vecs[6] = '{0, ~rk, 255, 0, 1027};
    vecs[7] = '{3, {rk[31:0], rk[127:32]}, 40, 0, 597};

    rst    = 1'b1;
    en     = '0;
    wr_clr = '0;
    key_v  = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("u%0d_reset_rdy", k), int'(rdy[k]), 1);
      chk($sformatf("u%0d_reset_wren", k), int'(pt_wren[k]), 0);
      chk($sformatf("u%0d_reset_ct_addr", k), int'(ct_addr[k]), 0);
      chk($sformatf("u%0d_reset_pt_addr", k), int'(pt_addr[k]), 0);
      chk($sformatf("u%0d_reset_pt_wrdata", k), int'(pt_wrdata[k]), 0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) run_vec(vecs[v]);

    // Asynchronous reset in the middle of PRGA, then a clean rerun.
    load_ct(0, 9, 1);
    start(0, 128'h4B6579);
    n = 0;
    while (ct_addr[0] != 8'd5 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach_prga_byte5", int'(ct_addr[0]), 5);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_rdy", int'(rdy[0]), 1);
    chk("async_rst_wren", int'(pt_wren[0]), 0);
    chk("async_rst_ct_addr", int'(ct_addr[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(vecs[0]);

    // en pulses and key changes while busy, then en held high through completion.
    load_ct(0, 9, 1);
    start(0, 128'h4B6579);
    n = 0;
    while (rdy[0] !== 1'b1 && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
      case (n)
        100: begin en[0] = 1'b1; key_v[0] = {$urandom, $urandom, $urandom, $urandom}; end
        101: en[0] = 1'b0;
        300: begin en[0] = 1'b1; key_v[0] = {$urandom, $urandom, $urandom, $urandom}; end
        302: en[0] = 1'b0;
        520: begin en[0] = 1'b1; key_v[0] = 128'h123456; end
        default: ;
      endcase
    end
    check_msg(0, 9, 128'h4B6579, 535, n, 1);
    wr_clr[0] = 1'b1;
    @(posedge clk);
    #1;
    wr_clr[0] = 1'b0;
    chk("b2b_accept_on_rdy_edge", int'(rdy[0]), 0);
    en[0] = 1'b0;
    wait_done(0, n);
    check_msg(0, 9, 128'h123456, 535, n, 0);

    // Random messages on random instances.
    for (int r = 0; r < 5; r++) begin
      u   = int'($urandom_range(0, 3));
      len = int'($urandom_range(0, 48));
      rk  = {$urandom, $urandom, $urandom, $urandom};
      load_ct(u, len, 0);
      start(u, rk);
      wait_done(u, n);
      check_msg(u, len, rk, 512 + drop_of(u) + 3 + 2 * len + 2, n, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
